pipe_packer: RTL and testbench

PIPE_PACKER -- requirements
Module: pipe_packer

---
 rtl/pipe_packer.sv | 105 ++++++++++
 tb/tb_pipe_packer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_packer.sv
// pipe_packer: packs 5-bit pipeline values into LANES-lane words with flush.
// Define PIPE_PACKER_PARITY_EN to add the per-lane even-parity output packed_par.
module pipe_packer #(
   parameter int LANES = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [4:0]         input_val,
   input  logic               pipe_in_valid,
   output logic               pipe_in_rdy,
   input  logic               flush_i,
   output logic [5*LANES-1:0] packed_val,
   output logic [3:0]         packed_cnt,
   output logic               pipe_out_valid,
`ifdef PIPE_PACKER_PARITY_EN
   output logic [LANES-1:0]   packed_par,
`endif
   input  logic               pipe_out_rdy
);

   typedef enum logic [1:0] {EMPTY, FILL, FLUSH_PEND} state_t;

   localparam logic [3:0] LAST = 4'(LANES - 1);
   localparam logic [3:0] FULL = 4'(LANES);

   state_t             state;
   logic [3:0]         fill_cnt;
   logic [5*LANES-1:0] acc;
   logic [5*LANES-1:0] acc_n;
   logic [3:0]         cnt_n;
   logic               out_free;
   logic               accept;
   logic               flush_req;
   logic               xfer;

   assign out_free    = !pipe_out_valid || pipe_out_rdy;
   assign pipe_in_rdy = !reset_i &&
                        (((fill_cnt < LAST) && (state != FLUSH_PEND)) || out_free);
   assign accept      = pipe_in_valid && pipe_in_rdy;
   assign cnt_n       = fill_cnt + {3'd0, accept};
   assign flush_req   = (flush_i || (state == FLUSH_PEND)) && (cnt_n != 4'd0);
   // a full word only arrives when the output register is free
   assign xfer        = out_free && ((cnt_n == FULL) || flush_req);

   always_comb begin
      acc_n = acc;
      for (int i = 0; i < LANES; i++) begin
         if (accept && (fill_cnt == 4'(i))) begin
            acc_n[5*i +: 5] = input_val;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state          <= EMPTY;
         fill_cnt       <= '0;
         acc            <= '0;
         packed_val     <= '0;
         packed_cnt     <= '0;
         pipe_out_valid <= 1'b0;
      end else if (xfer) begin
         packed_val     <= acc_n;
         packed_cnt     <= cnt_n;
         pipe_out_valid <= 1'b1;
         acc            <= '0;
         fill_cnt       <= '0;
         state          <= EMPTY;
      end else begin
         if (pipe_out_rdy) begin
            pipe_out_valid <= 1'b0;
         end
         acc      <= acc_n;
         fill_cnt <= cnt_n;
         if (flush_req) begin
            state <= FLUSH_PEND;
         end else if (cnt_n != 4'd0) begin
            state <= FILL;
         end else begin
            state <= EMPTY;
         end
      end
   end

`ifdef PIPE_PACKER_PARITY_EN
   logic [LANES-1:0] par_n;

   // lanes beyond the count are zero, so their parity is zero too
   always_comb begin
      par_n = '0;
      for (int i = 0; i < LANES; i++) begin
         par_n[i] = ^acc_n[5*i +: 5];
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         packed_par <= '0;
      end else if (xfer) begin
         packed_par <= par_n;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_packer.sv
// tb_pipe_packer: directed vectors for pipe_packer with LANES=4.
// Parity is checked only when PIPE_PACKER_PARITY_EN is defined.
module tb_pipe_packer;

   logic        clk_i;
   logic        reset_i;
   logic [4:0]  input_val;
   logic        pipe_in_valid;
   logic        pipe_in_rdy;
   logic        flush_i;
   logic [19:0] packed_val;
   logic [3:0]  packed_cnt;
   logic        pipe_out_valid;
   logic        pipe_out_rdy;
`ifdef PIPE_PACKER_PARITY_EN
   logic [3:0]  packed_par;
`endif

   int total = 0;
   int bad = 0;

   pipe_packer #(.LANES(4)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .input_val      (input_val),
      .pipe_in_valid  (pipe_in_valid),
      .pipe_in_rdy    (pipe_in_rdy),
      .flush_i        (flush_i),
      .packed_val     (packed_val),
      .packed_cnt     (packed_cnt),
      .pipe_out_valid (pipe_out_valid),
`ifdef PIPE_PACKER_PARITY_EN
      .packed_par     (packed_par),
`endif
      .pipe_out_rdy   (pipe_out_rdy)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic beat(input logic [4:0] v);
      pipe_in_valid = 1'b1;
      input_val     = v;
      step();
      pipe_in_valid = 1'b0;
   endtask

   function automatic logic [31:0] w4(input logic [4:0] a, input logic [4:0] b,
                                      input logic [4:0] c, input logic [4:0] d);
      return {12'd0, d, c, b, a};
   endfunction

   initial begin
      reset_i       = 1'b1;
      input_val     = '0;
      pipe_in_valid = 1'b0;
      flush_i       = 1'b0;
      pipe_out_rdy  = 1'b1;

      #12;
      chk("rst_valid", 32'(pipe_out_valid), 32'd0);
      chk("rst_val",   32'(packed_val),     32'd0);
      chk("rst_cnt",   32'(packed_cnt),     32'd0);
      chk("rst_rdy",   32'(pipe_in_rdy),    32'd0);
      #10;
      reset_i = 1'b0;
      #1;
      chk("rdy_after_rst", 32'(pipe_in_rdy), 32'd1);
      step();

      // four beats -> full word one cycle after the last
      beat(5'd1);
      beat(5'd2);
      beat(5'd3);
      chk("full_early", 32'(pipe_out_valid), 32'd0);
      beat(5'd4);
      chk("full_valid", 32'(pipe_out_valid), 32'd1);
      chk("full_val",   32'(packed_val),     32'h20C41);
      chk("full_cnt",   32'(packed_cnt),     32'd4);
      step();
      chk("full_drain", 32'(pipe_out_valid), 32'd0);

      // partial word via flush
      beat(5'd5);
      beat(5'd6);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("flush_valid", 32'(pipe_out_valid), 32'd1);
      chk("flush_val",   32'(packed_val),     32'h000C5);
      chk("flush_cnt",   32'(packed_cnt),     32'd2);
      step();

      // flush while empty is ignored
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("empty_flush", 32'(pipe_out_valid), 32'd0);

      // flush together with the 4th beat is one full word
      beat(5'd7);
      beat(5'd8);
      beat(5'd9);
      flush_i = 1'b1;
      beat(5'd10);
      flush_i = 1'b0;
      chk("fl4_val", 32'(packed_val), w4(5'd7, 5'd8, 5'd9, 5'd10));
      chk("fl4_cnt", 32'(packed_cnt), 32'd4);
      step();
      chk("fl4_single", 32'(pipe_out_valid), 32'd0);

      // backpressure: word held, 3 beats buffered, 4th stalls
      pipe_out_rdy = 1'b0;
      beat(5'd1);
      beat(5'd2);
      beat(5'd3);
      beat(5'd4);
      beat(5'd5);
      beat(5'd6);
      beat(5'd7);
      pipe_in_valid = 1'b1;
      input_val     = 5'd8;
      #1;
      chk("bp_rdy_low", 32'(pipe_in_rdy), 32'd0);
      step();
      step();
      chk("bp_rdy_hold", 32'(pipe_in_rdy),    32'd0);
      chk("bp_valid",    32'(pipe_out_valid), 32'd1);
      chk("bp_val",      32'(packed_val),     w4(5'd1, 5'd2, 5'd3, 5'd4));
      chk("bp_cnt",      32'(packed_cnt),     32'd4);
      pipe_out_rdy = 1'b1;
      step();
      pipe_in_valid = 1'b0;
      chk("bp_resume_valid", 32'(pipe_out_valid), 32'd1);
      chk("bp_resume_val",   32'(packed_val),     w4(5'd5, 5'd6, 5'd7, 5'd8));
      step();
      chk("bp_drain", 32'(pipe_out_valid), 32'd0);

      // flush while output busy -> pending, completes when drained
      pipe_out_rdy = 1'b0;
      beat(5'd1);
      beat(5'd2);
      beat(5'd3);
      beat(5'd4);
      flush_i = 1'b1;
      beat(5'd21);
      flush_i = 1'b0;
      #1;
      chk("pend_rdy", 32'(pipe_in_rdy), 32'd0);
      step();
      chk("pend_hold", 32'(packed_val), w4(5'd1, 5'd2, 5'd3, 5'd4));
      pipe_out_rdy = 1'b1;
      step();
      chk("pend_valid", 32'(pipe_out_valid), 32'd1);
      chk("pend_val",   32'(packed_val),     32'd21);
      chk("pend_cnt",   32'(packed_cnt),     32'd1);
      step();

      // streaming: one word every 4 cycles, never stalled
      for (int i = 0; i < 12; i++) begin
         pipe_in_valid = 1'b1;
         input_val     = 5'(i + 1);
         #1;
         chk("stream_rdy", 32'(pipe_in_rdy), 32'd1);
         @(posedge clk_i);
         #1;
         chk("stream_valid", 32'(pipe_out_valid), ((i % 4) == 3) ? 32'd1 : 32'd0);
      end
      pipe_in_valid = 1'b0;
      chk("stream_last", 32'(packed_val), w4(5'd9, 5'd10, 5'd11, 5'd12));
      step();

      // asynchronous reset mid-word
      pipe_out_rdy = 1'b0;
      beat(5'd1);
      beat(5'd2);
      beat(5'd3);
      beat(5'd4);
      beat(5'd5);
      beat(5'd6);
      #2;
      reset_i = 1'b1;
      #1;
      chk("arst_valid", 32'(pipe_out_valid), 32'd0);
      chk("arst_val",   32'(packed_val),     32'd0);
      chk("arst_cnt",   32'(packed_cnt),     32'd0);
      chk("arst_rdy",   32'(pipe_in_rdy),    32'd0);
      #3;
      reset_i = 1'b0;
      step();
      pipe_out_rdy = 1'b1;
      chk("arst_rdy_back", 32'(pipe_in_rdy), 32'd1);
      beat(5'd17);
      beat(5'd18);
      beat(5'd19);
      beat(5'd20);
      chk("arst_val2", 32'(packed_val), w4(5'd17, 5'd18, 5'd19, 5'd20));
      chk("arst_cnt2", 32'(packed_cnt), 32'd4);
      step();

      // parity vector
      beat(5'd3);
      beat(5'd1);
      beat(5'd0);
      beat(5'd7);
      chk("par_val", 32'(packed_val), w4(5'd3, 5'd1, 5'd0, 5'd7));
`ifdef PIPE_PACKER_PARITY_EN
      chk("par_bits", 32'(packed_par), 32'b1010);
`endif
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
